// File: rtl/seq_detect_moore_param_pkg.sv
// seq_detect_moore_param_pkg: shared constants and helpers for the pattern detector
package seq_detect_moore_param_pkg;
  localparam logic [4:0] DEFAULT_PATTERN = 5'b10110;
  localparam int N_MIN = 2;
  localparam int N_MAX = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/seq_detect_moore_param_sat_counter.sv
// sat_counter: saturating up-counter with clear taking priority over increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  // count up on inc, stick at all-ones, clear wins
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/seq_detect_moore_param.sv
// seq_detect_moore_param: Moore serial pattern detector with reloadable pattern and match counter
module seq_detect_moore_param
  import seq_detect_moore_param_pkg::*;
#(
  parameter int             N       = 5,
  parameter logic [N-1:0]   PATTERN = N'(DEFAULT_PATTERN),
  parameter int             CNT_W   = 8,
  localparam int            SW      = clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             ovl,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [SW-1:0]    state
);
  logic [SW-1:0] k, k_next, hist_len, eff_len, len_next;
  logic [N-2:0]  hist;
  logic [N-1:0]  pat, cand;
  logic          hit;
  // longest pattern prefix that ends the eligible candidate string; a finished
  // match in non-overlap mode forgets all history before the new bit
  always_comb begin
    eff_len = (!ovl && k == SW'(N)) ? '0 : hist_len;
    len_next = (eff_len == SW'(N)) ? eff_len : eff_len + 1'b1;
    cand = {hist, in};
    k_next = '0;
    for (int j = 1; j <= N; j++)
      if (j <= int'(eff_len) + 1 && ((cand ^ (pat >> (N - j))) & N'((1 << j) - 1)) == '0)
        k_next = SW'(j);
    hit = en && !cfg_load && k_next == SW'(N);
  end
  // matched-prefix length, bit history and active pattern
  always_ff @(posedge clk)
    if (rst) begin
      k <= '0;
      hist_len <= '0;
      hist <= '0;
      pat <= PATTERN;
    end else if (cfg_load) begin
      k <= '0;
      hist_len <= '0;
      hist <= '0;
      pat <= cfg_pattern;
    end else if (en) begin
      k <= k_next;
      hist_len <= len_next;
      hist <= cand[N-2:0];
    end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit),
    .clr(clr_cnt),
    .q  (match_cnt)
  );
  assign out = (k == SW'(N));
  assign state = k;
endmodule

// File: tb/tb_seq_detect_moore_param.sv
// tb_seq_detect_moore_param: table vectors, small-counter corner cases and randomized model check
module tb_seq_detect_moore_param;
  logic clk = 0, rst = 0, en = 0, in = 0, ovl = 0, cfg_load = 0, clr_cnt = 0;
  logic [4:0] cfg_pattern = '0;
  logic out;
  logic [7:0] match_cnt;
  logic [2:0] state;
  logic s_cfg = 0;
  logic [1:0] s_pat = 2'b11;
  logic s_out;
  logic [1:0] s_cnt, s_state;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seq_detect_moore_param dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .ovl(ovl), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .clr_cnt(clr_cnt), .out(out), .match_cnt(match_cnt), .state(state)
  );

  seq_detect_moore_param #(.N(2), .PATTERN(2'b11), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in(in), .ovl(ovl), .cfg_load(s_cfg),
    .cfg_pattern(s_pat), .clr_cnt(clr_cnt), .out(s_out), .match_cnt(s_cnt), .state(s_state)
  );

  typedef struct {
    bit r, e, b, o, c;
    logic [4:0] cp;
    bit cl;
    int eo, es, ec;
  } vec_t;
  vec_t tbl[$];

  function automatic void chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endfunction

  function automatic void add(bit r, bit e, bit b, bit o, bit c, logic [4:0] cp, bit cl, int es, int ec);
    vec_t v;
    v.r = r; v.e = e; v.b = b; v.o = o; v.c = c; v.cp = cp; v.cl = cl;
    v.es = es; v.ec = ec; v.eo = (es == 5) ? 1 : 0;
    tbl.push_back(v);
  endfunction

  task automatic drive(bit r, bit e, bit b, bit o, bit c, logic [4:0] cp, bit cl);
    rst = r; en = e; in = b; ovl = o; cfg_load = c; cfg_pattern = cp; clr_cnt = cl;
    @(posedge clk);
    #1;
  endtask

  bit elig[$];
  logic [4:0] m_pat;
  int m_k, m_cnt;

  task automatic model_step(bit r, bit e, bit b, bit o, bit c, logic [4:0] cp, bit cl);
    bit hit, ok;
    hit = 0;
    if (r) begin
      elig.delete(); m_pat = 5'b10110; m_k = 0; m_cnt = 0;
      return;
    end
    if (c) begin
      m_pat = cp; elig.delete(); m_k = 0;
    end else if (e) begin
      if (!o && m_k == 5) elig.delete();
      elig.push_back(b);
      if (elig.size() > 5) void'(elig.pop_front());
      m_k = 0;
      for (int j = 1; j <= elig.size(); j++) begin
        ok = 1;
        for (int i = 0; i < j; i++)
          if (elig[elig.size() - j + i] != m_pat[4 - i]) ok = 0;
        if (ok) m_k = j;
      end
      hit = (m_k == 5);
    end
    if (cl) m_cnt = 0;
    else if (hit && m_cnt < 255) m_cnt++;
  endtask

  initial begin
    int s1[10] = '{0, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    int c1[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 2};
    int s2[10] = '{0, 0, 1, 2, 3, 4, 5, 1, 1, 2};
    int so[8]  = '{1, 2, 3, 4, 5, 1, 2, 3};
    bit str[10] = '{0, 0, 1, 0, 1, 1, 0, 1, 1, 0};
    bit rr, ee, bb, oo, cc, cl;
    logic [4:0] cp;
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 1, str[i], 1, 0, 0, 0, s1[i], c1[i]);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 1, str[i], 0, 0, 0, 0, s2[i], (i >= 6) ? 1 : 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 1, str[i], 1, 0, 0, 0, s1[i], 0);
    add(0, 0, 0, 1, 0, 0, 0, 4, 0);
    add(0, 0, 1, 1, 0, 0, 0, 4, 0);
    add(0, 0, 0, 0, 0, 0, 0, 4, 0);
    for (int i = 6; i < 10; i++) add(0, 1, str[i], 1, 0, 0, 0, s1[i], c1[i]);
    add(0, 1, 1, 1, 1, 5'b11111, 0, 0, 2);
    for (int i = 0; i < 8; i++) add(0, 1, 1, 1, 0, 0, 0, (i < 4) ? i + 1 : 5, (i < 4) ? 2 : i - 1);
    add(0, 1, 1, 0, 1, 5'b11111, 1, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 1, 0, 0, 0, 0, so[i], (i >= 4) ? 1 : 0);
    add(0, 1, 1, 0, 0, 0, 0, 4, 1);
    add(0, 1, 1, 0, 0, 0, 0, 5, 2);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0, 0, 2, 0);
    add(0, 1, 1, 1, 0, 0, 0, 3, 0);
    add(0, 1, 1, 1, 0, 0, 0, 4, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0, 0, 2, 0);
    add(0, 1, 1, 1, 0, 0, 0, 3, 0);
    add(0, 1, 1, 1, 0, 0, 0, 4, 0);
    add(0, 1, 0, 1, 0, 0, 0, 5, 1);
    add(0, 1, 1, 1, 0, 0, 0, 3, 1);
    add(0, 1, 1, 1, 0, 0, 0, 4, 1);
    add(0, 1, 0, 1, 0, 0, 1, 5, 0);
    add(0, 1, 1, 1, 0, 0, 0, 3, 0);
    add(0, 0, 1, 1, 0, 0, 0, 3, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].b, tbl[i].o, tbl[i].c, tbl[i].cp, tbl[i].cl);
      chk("tbl_state", i, 32'(state), 32'(tbl[i].es));
      chk("tbl_out", i, 32'(out), 32'(tbl[i].eo));
      chk("tbl_cnt", i, 32'(match_cnt), 32'(tbl[i].ec));
    end

    drive(1, 0, 0, 1, 0, 0, 0);
    chk("sat_rst_cnt", 0, 32'(s_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 1, 0, 0, 0);
      chk("sat_state", i, 32'(s_state), (i == 0) ? 1 : 2);
      chk("sat_out", i, 32'(s_out), (i == 0) ? 0 : 1);
      chk("sat_cnt", i, 32'(s_cnt), (i < 3) ? i : 3);
    end
    drive(0, 1, 1, 1, 0, 0, 1);
    chk("sat_clr_cnt", 0, 32'(s_cnt), 0);
    chk("sat_clr_out", 0, 32'(s_out), 1);
    drive(0, 1, 1, 1, 0, 0, 0);
    chk("sat_after_clr", 0, 32'(s_cnt), 1);

    drive(1, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      ee = ($urandom_range(0, 9) < 8);
      bb = 1'($urandom);
      oo = ($urandom_range(0, 3) != 0);
      cc = ($urandom_range(0, 59) == 0);
      cp = 5'($urandom);
      cl = ($urandom_range(0, 39) == 0);
      model_step(rr, ee, bb, oo, cc, cp, cl);
      drive(rr, ee, bb, oo, cc, cp, cl);
      chk("rnd_state", i, 32'(state), 32'(m_k));
      chk("rnd_out", i, 32'(out), (m_k == 5) ? 1 : 0);
      chk("rnd_cnt", i, 32'(match_cnt), 32'(m_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
